// File: rtl/mem_port_arbiter_if.sv
// Shared memory port bus between fetch (I), load/store (D) and unified memory.
// The arbiter uses the slave view; requesters and memory sit on the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_be;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              addr_sel;
    logic              busy;

    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_ready,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_rdata, d_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ready,
        output addr_sel, busy
    );

    modport master (
        output i_req, i_addr,
        input  i_rdata, i_ready,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_rdata, d_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ready,
        input  addr_sel, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// I/D arbiter for the unified memory port; D has priority over I.
// Define ARB_FAIRNESS_EN to cap consecutive D grants while I waits.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   i_turn;
    logic   grant_i;
    logic   grant_d;
    logic   i_own;
    logic   d_own;

    if (MAX_D_STREAK < 1) begin : g_bad_cfg
        $error("MAX_D_STREAK must be at least 1");
    end

`ifdef ARB_FAIRNESS_EN
    localparam int STREAK_W = $clog2(MAX_D_STREAK) + 1;
    logic [STREAK_W-1:0] streak;

    assign i_turn = (streak == STREAK_W'(MAX_D_STREAK));

    always_ff @(posedge clk) begin
        if (rst)
            streak <= '0;
        else if (grant_i)
            streak <= '0;
        else if (grant_d)
            streak <= bus.i_req ? streak + STREAK_W'(1) : '0;
    end
`else
    assign i_turn = 1'b0;
`endif

    // Grants are only issued from IDLE, which forces a bubble after each ready.
    assign grant_d = (state == IDLE) && bus.d_req && !(bus.i_req && i_turn);
    assign grant_i = (state == IDLE) && bus.i_req && !grant_d;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant_d)
                    state_nxt = GNT_D;
                else if (grant_i)
                    state_nxt = GNT_I;
            end
            GNT_I, GNT_D: begin
                if (bus.mem_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        i_own         = (state == GNT_I);
        d_own         = (state == GNT_D);
        bus.mem_req   = i_own || d_own;
        bus.busy      = (state != IDLE);
        bus.addr_sel  = d_own;
        bus.mem_addr  = d_own ? bus.d_addr : bus.i_addr;
        bus.mem_we    = d_own && bus.d_we;
        bus.mem_be    = d_own ? bus.d_be : 4'hF;
        bus.mem_wdata = d_own ? bus.d_wdata : '0;
        bus.i_ready   = i_own && bus.mem_ready;
        bus.d_ready   = d_own && bus.mem_ready;
        bus.i_rdata   = i_own ? bus.mem_rdata : '0;
        bus.d_rdata   = d_own ? bus.mem_rdata : '0;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus multi-cycle sequences.
// Honours ARB_FAIRNESS_EN for the back-to-back D streak expectation.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_D_STREAK(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        ireq;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        int          lat;
        logic [31:0] rdata;
        logic        exp_sel;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_req     = 1'b0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic serve_grant(input logic exp_sel, input string tag);
        chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd1);
        chk({tag, "_sel"}, 32'(bus.addr_sel), 32'(exp_sel));
        bus.mem_ready = 1'b1;
        #1;
        chk({tag, "_rdy"}, exp_sel ? 32'(bus.d_ready) : 32'(bus.i_ready), 32'd1);
        tick();
        bus.mem_ready = 1'b0;
        #1;
        chk({tag, "_bubble"}, 32'(bus.busy), 32'd0);
        tick();
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0040_0000, 32'h0, 32'h0,
                    3, 32'h2008_0005,
                    1'b0, 1'b0, 4'hF, 32'h0040_0000, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h1001_0004, 32'hAAAA_5555,
                    1, 32'h1234_5678,
                    1'b1, 1'b0, 4'hF, 32'h1001_0004, 32'hAAAA_5555};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 4'b0011, 32'h0040_0010, 32'h1001_0000,
                    32'hDEAD_BEEF, 2, 32'h0,
                    1'b1, 1'b1, 4'b0011, 32'h1001_0000, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 4'b1100, 32'h0, 32'h1001_0008,
                    32'hCAFE_F00D, 0, 32'h0BAD_0BAD,
                    1'b1, 1'b1, 4'b1100, 32'h1001_0008, 32'hCAFE_F00D};

        // reset held two cycles with both requesting
        idle_inputs();
        bus.i_addr  = 32'h0040_0000;
        bus.d_addr  = 32'h1001_0000;
        bus.d_wdata = 32'h0;
        bus.d_be    = 4'hF;
        bus.i_req   = 1'b1;
        bus.d_req   = 1'b1;
        rst         = 1'b1;
        tick();
        tick();
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_sel", 32'(bus.addr_sel), 32'd0);
        chk("rst_i_ready", 32'(bus.i_ready), 32'd0);
        chk("rst_d_ready", 32'(bus.d_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_first_gnt_req", 32'(bus.mem_req), 32'd1);
        chk("rst_first_gnt_sel", 32'(bus.addr_sel), 32'd1);
        bus.mem_ready = 1'b1;
        #1;
        chk("rst_first_d_ready", 32'(bus.d_ready), 32'd1);
        tick();
        idle_inputs();
        tick();

        for (int k = 0; k < 4; k++) begin
            bus.i_addr  = vecs[k].iaddr;
            bus.d_addr  = vecs[k].daddr;
            bus.d_wdata = vecs[k].dwdata;
            bus.d_be    = vecs[k].dbe;
            bus.d_we    = vecs[k].dwe;
            bus.i_req   = vecs[k].ireq;
            bus.d_req   = vecs[k].dreq;
            tick();
            chk($sformatf("v%0d_mem_req", k), 32'(bus.mem_req), 32'd1);
            chk($sformatf("v%0d_busy", k), 32'(bus.busy), 32'd1);
            chk($sformatf("v%0d_sel", k), 32'(bus.addr_sel), 32'(vecs[k].exp_sel));
            chk($sformatf("v%0d_we", k), 32'(bus.mem_we), 32'(vecs[k].exp_we));
            chk($sformatf("v%0d_be", k), 32'(bus.mem_be), 32'(vecs[k].exp_be));
            chk($sformatf("v%0d_addr", k), bus.mem_addr, vecs[k].exp_addr);
            chk($sformatf("v%0d_wdata", k), bus.mem_wdata, vecs[k].exp_wdata);
            for (int w = 0; w < vecs[k].lat; w++) begin
                chk($sformatf("v%0d_early_rdy", k),
                    32'(bus.i_ready | bus.d_ready), 32'd0);
                tick();
            end
            bus.mem_ready = 1'b1;
            bus.mem_rdata = vecs[k].rdata;
            #1;
            if (vecs[k].exp_sel) begin
                chk($sformatf("v%0d_d_ready", k), 32'(bus.d_ready), 32'd1);
                chk($sformatf("v%0d_i_ready", k), 32'(bus.i_ready), 32'd0);
                chk($sformatf("v%0d_d_rdata", k), bus.d_rdata, vecs[k].rdata);
                chk($sformatf("v%0d_i_rdata", k), bus.i_rdata, 32'h0);
            end else begin
                chk($sformatf("v%0d_i_ready", k), 32'(bus.i_ready), 32'd1);
                chk($sformatf("v%0d_d_ready", k), 32'(bus.d_ready), 32'd0);
                chk($sformatf("v%0d_i_rdata", k), bus.i_rdata, vecs[k].rdata);
                chk($sformatf("v%0d_d_rdata", k), bus.d_rdata, 32'h0);
            end
            tick();
            idle_inputs();
            #1;
            chk($sformatf("v%0d_idle_busy", k), 32'(bus.busy), 32'd0);
            chk($sformatf("v%0d_idle_req", k), 32'(bus.mem_req), 32'd0);
            tick();
            chk($sformatf("v%0d_no_regrant", k), 32'(bus.busy), 32'd0);
        end

        // simultaneous: D store first, bubble, then I
        bus.i_addr  = 32'h0040_0020;
        bus.d_addr  = 32'h1001_0000;
        bus.d_wdata = 32'hDEAD_BEEF;
        bus.d_be    = 4'b0011;
        bus.d_we    = 1'b1;
        bus.i_req   = 1'b1;
        bus.d_req   = 1'b1;
        tick();
        chk("sim_d_sel", 32'(bus.addr_sel), 32'd1);
        chk("sim_d_we", 32'(bus.mem_we), 32'd1);
        chk("sim_d_be", 32'(bus.mem_be), 32'h3);
        bus.mem_ready = 1'b1;
        #1;
        chk("sim_d_ready", 32'(bus.d_ready), 32'd1);
        chk("sim_i_not_ready", 32'(bus.i_ready), 32'd0);
        tick();
        bus.mem_ready = 1'b0;
        bus.d_req     = 1'b0;
        #1;
        chk("sim_bubble_req", 32'(bus.mem_req), 32'd0);
        tick();
        chk("sim_i_gnt_req", 32'(bus.mem_req), 32'd1);
        chk("sim_i_sel", 32'(bus.addr_sel), 32'd0);
        chk("sim_i_addr", bus.mem_addr, 32'h0040_0020);
        chk("sim_i_we", 32'(bus.mem_we), 32'd0);
        chk("sim_i_be", 32'(bus.mem_be), 32'hF);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0123_4567;
        #1;
        chk("sim_i_ready", 32'(bus.i_ready), 32'd1);
        chk("sim_i_rdata", bus.i_rdata, 32'h0123_4567);
        tick();
        idle_inputs();
        tick();

        // back-to-back D with I waiting
        bus.d_we  = 1'b0;
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        for (int g = 0; g < 5; g++) begin
            tick();
`ifdef ARB_FAIRNESS_EN
            serve_grant(g < 4, $sformatf("streak%0d", g));
`else
            serve_grant(1'b1, $sformatf("streak%0d", g));
`endif
        end
        idle_inputs();
        tick();

        // reset while D owns the port
        bus.d_req = 1'b1;
        tick();
        chk("rmid_gnt", 32'(bus.addr_sel), 32'd1);
        rst = 1'b1;
        tick();
        chk("rmid_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rmid_busy", 32'(bus.busy), 32'd0);
        rst           = 1'b0;
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        chk("rmid_late_d_ready", 32'(bus.d_ready), 32'd0);
        tick();
        chk("rmid_idle", 32'(bus.busy), 32'd0);
        bus.mem_ready = 1'b0;
        tick();

        // spurious mem_ready with nothing outstanding
        bus.mem_ready = 1'b1;
        #1;
        chk("spur_i_ready", 32'(bus.i_ready), 32'd0);
        chk("spur_d_ready", 32'(bus.d_ready), 32'd0);
        tick();
        chk("spur_idle", 32'(bus.busy), 32'd0);
        bus.mem_ready = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
